data_synchronizer: RTL

- Destination-domain stage of a multi-cycle-path (MCP) clock-domain crossing.
- The source domain holds a data bus stable and raises a level enable. This block synchronises the enable through a flop chain and detects its rising edge.
- On that edge it captures the bus and presents it to the local consumer through a valid/ready handshake.
- It sits directly downstream of the CDC boundary and feeds register-file and UART-side logic.

---
 rtl/data_sync_pkg.sv | 14 +
 rtl/data_synchronizer_if.sv | 37 +++
 rtl/data_synchronizer_pulse_gen.sv | 20 ++
 rtl/data_synchronizer.sv | 75 +++++++
 4 files changed

// File: rtl/data_sync_pkg.sv
// Shared constants for the MCP-CDC destination stage (data_synchronizer).
package data_sync_pkg;

  localparam logic DS_IDLE      = 1'b0;
  localparam logic DS_FULL      = 1'b1;
  localparam int   DS_BUS_WIDTH = 8;
  localparam int   DS_OVR_CNT_W = 8;

  typedef enum logic {
    ST_IDLE = DS_IDLE,
    ST_FULL = DS_FULL
  } ds_state_e;

endpackage

// File: rtl/data_synchronizer_if.sv
// Crossed bus plus consumer handshake for data_synchronizer.
// DATA_SYNC_OVERRUN_COUNT_EN adds the overrun_count signal.
interface data_synchronizer_if
  import data_sync_pkg::*;
#(
  parameter int BUS_WIDTH = DS_BUS_WIDTH
);

  logic [BUS_WIDTH-1:0]    unsync_bus;
  logic                    bus_enable;
  logic                    sync_ready;
  logic [BUS_WIDTH-1:0]    sync_bus;
  logic                    sync_valid;
  logic                    enable_pulse;
  logic                    overrun;
`ifdef DATA_SYNC_OVERRUN_COUNT_EN
  logic [DS_OVR_CNT_W-1:0] overrun_count;
`endif

  // The synchroniser is the slave of the source/consumer side.
  modport slave (
    input  unsync_bus, bus_enable, sync_ready,
`ifdef DATA_SYNC_OVERRUN_COUNT_EN
    output overrun_count,
`endif
    output sync_bus, sync_valid, enable_pulse, overrun
  );

  modport master (
    output unsync_bus, bus_enable, sync_ready,
`ifdef DATA_SYNC_OVERRUN_COUNT_EN
    input  overrun_count,
`endif
    input  sync_bus, sync_valid, enable_pulse, overrun
  );

endinterface

// File: rtl/data_synchronizer_pulse_gen.sv
// Rising-edge detector on the synchronised enable (holds en_prev).
module pulse_gen (
  input  logic clk,
  input  logic reset,
  input  logic en_sync,
  output logic rise
);

  logic en_prev;

  // NOTE: reset is synchronous here, so it lives inside the clocked branch
  // and is not in the sensitivity list; sequential state uses <= only.
  always_ff @(posedge clk) begin
    if (reset) en_prev <= 1'b0;
    else       en_prev <= en_sync;
  end

  assign rise = en_sync & ~en_prev;

endmodule

// File: rtl/data_synchronizer.sv
// MCP CDC destination stage: synchronise bus_enable, capture on its rise,
// hand data to the consumer via valid/ready. Option: DATA_SYNC_OVERRUN_COUNT_EN.
module data_synchronizer
  import data_sync_pkg::*;
#(
  parameter int STAGE_COUNT = 2,
  parameter int BUS_WIDTH   = DS_BUS_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  data_synchronizer_if.slave bus
);

  logic [STAGE_COUNT-1:0] sync_chain;
  logic                   en_sync;
  logic                   rise;
  logic                   ovr_next;
  ds_state_e              state;
  logic [BUS_WIDTH-1:0]   sync_bus_q;
  logic                   enable_pulse_q;
  logic                   overrun_q;

  always_ff @(posedge clk) begin
    if (reset) sync_chain <= '0;
    else       sync_chain <= {sync_chain[STAGE_COUNT-2:0], bus.bus_enable};
  end

  assign en_sync = sync_chain[STAGE_COUNT-1];

  pulse_gen u_pulse_gen (
    .clk     (clk),
    .reset   (reset),
    .en_sync (en_sync),
    .rise    (rise)
  );

  // A fresh capture while unconsumed data is pending and nobody is reading it.
  assign ovr_next = rise & (state == ST_FULL) & ~bus.sync_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      sync_bus_q     <= '0;
      enable_pulse_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      enable_pulse_q <= rise;
      overrun_q      <= ovr_next;
      if (rise) sync_bus_q <= bus.unsync_bus;
      case (state)
        ST_IDLE: if (rise) state <= ST_FULL;
        ST_FULL: if (bus.sync_ready && !rise) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sync_bus     = sync_bus_q;
  assign bus.sync_valid   = (state == ST_FULL);
  assign bus.enable_pulse = enable_pulse_q;
  assign bus.overrun      = overrun_q;

`ifdef DATA_SYNC_OVERRUN_COUNT_EN
  logic [DS_OVR_CNT_W-1:0] ovr_cnt;

  // Saturates at all-ones; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)                        ovr_cnt <= '0;
    else if (ovr_next && ovr_cnt != '1) ovr_cnt <= ovr_cnt + 1'b1;
  end

  assign bus.overrun_count = ovr_cnt;
`endif

endmodule
